// File: rtl/cpu_decode_pipe.sv
// Decode stage: field split, register file read with optional bypass,
// load-use hazard bubbles and a ready/valid ID/EX output register.
module cpu_decode_pipe #(
  parameter int WIDTH    = 32,
  parameter int NREGS    = 32,
  parameter int SIGN_EXT = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] instr,
  input  logic             wb_we,
  input  logic [4:0]       wb_wnum,
  input  logic [WIDTH-1:0] wb_wdata,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rdata1,
  output logic [WIDTH-1:0] out_rdata2,
  output logic [WIDTH-1:0] out_imm,
  output logic [WIDTH-1:0] out_addr,
  output logic [5:0]       out_opcode,
  output logic [5:0]       out_funct,
  output logic [4:0]       out_shamt,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_dst,
  output logic [15:0]      stall_cnt
);

  logic [WIDTH-1:0] rf [32];

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] addr_ext;
  logic [WIDTH-1:0] rdata1;
  logic [WIDTH-1:0] rdata2;
  logic             hazard;
  logic             load_en;
  logic             accept;
  logic             unused_hi;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];

  assign unused_hi = ^instr;

  assign imm_ext = (SIGN_EXT != 0)
    ? {{(WIDTH-16){instr[15]}}, instr[15:0]}
    : {{(WIDTH-16){1'b0}}, instr[15:0]};
  assign addr_ext = {{(WIDTH-26){1'b0}}, instr[25:0]};

  function automatic logic [WIDTH-1:0] rd_port(
    input logic [4:0]       idx,
    input logic [WIDTH-1:0] stored,
    input logic             we,
    input logic [4:0]       wnum,
    input logic [WIDTH-1:0] wdata
  );
    if (idx == 5'd0 || int'(idx) >= NREGS)
      return '0;
    if (BYPASS != 0 && we && wnum == idx)
      return wdata;
    return stored;
  endfunction

  assign rdata1 = rd_port(rs, rf[rs], wb_we, wb_wnum, wb_wdata);
  assign rdata2 = rd_port(rt, rf[rt], wb_we, wb_wnum, wb_wdata);

  assign hazard = in_valid & ex_is_load & (ex_rt != 5'd0)
                & ((ex_rt == rs) | (ex_rt == rt));
  assign load_en  = ~out_valid | out_ready;
  assign accept   = in_valid & ~hazard;
  assign in_ready = flush | (load_en & ~hazard);

  // Entry 0 and entries at or above NREGS are never written, so stay zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++)
        if (i < NREGS && wb_we && wb_wnum == 5'(i))
          rf[i] <= wb_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_rdata1 <= '0;
      out_rdata2 <= '0;
      out_imm    <= '0;
      out_addr   <= '0;
      out_opcode <= '0;
      out_funct  <= '0;
      out_shamt  <= '0;
      out_rs     <= '0;
      out_rt     <= '0;
      out_dst    <= '0;
      stall_cnt  <= '0;
    end else begin
      if (hazard && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (load_en) begin
        out_valid <= accept;
        if (accept) begin
          out_rdata1 <= rdata1;
          out_rdata2 <= rdata2;
          out_imm    <= imm_ext;
          out_addr   <= addr_ext;
          out_opcode <= opcode;
          out_funct  <= funct;
          out_shamt  <= shamt;
          out_rs     <= rs;
          out_rt     <= rt;
          out_dst    <= (opcode == 6'd0) ? rd : rt;
        end
      end
    end
  end

endmodule
